// File: rtl/fft_frame_feeder_if.sv
// Avalon-ST time-domain sink bus between the frame feeder (master) and the FFT core (slave).
interface fft_frame_feeder_if #(
  parameter int SAMPLE_W = 16
);
  logic                sink_valid;
  logic                sink_ready;
  logic                sink_sop;
  logic                sink_eop;
  logic [SAMPLE_W-1:0] sink_real;
  logic [SAMPLE_W-1:0] sink_imag;
  logic [1:0]          sink_error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    output sink_ready
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Collects (optionally block-averaged) audio samples into a single frame buffer,
// then streams the frame to the FFT sink with sop/eop framing.
module fft_frame_feeder #(
  parameter int FFT_POINTS = 1024,
  parameter int DECIM      = 1,
  parameter int SAMPLE_W   = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic [31:0]                   sample_in,
  fft_frame_feeder_if.master            sink,
  output logic [$clog2(FFT_POINTS):0]   fftpts_in,
  output logic                          dropped,
  output logic                          busy
);
  localparam int AW  = $clog2(FFT_POINTS);
  localparam int LD  = $clog2(DECIM);
  localparam int DW  = (LD > 0) ? LD : 1;
  localparam int ACW = SAMPLE_W + LD;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FFT_POINTS - 1);
  localparam logic [DW-1:0] DLAST     = DW'(DECIM - 1);
  localparam logic [0:0] FILL   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]                 state;
  logic [AW-1:0]              wr_addr, rd_addr;
  logic                       rd_done;
  logic [DW-1:0]              dcnt;
  logic signed [ACW-1:0]      acc, sum;
  logic signed [SAMPLE_W-1:0] s, wdata, rd_data;
  logic                       fill_go, we, rd_en, adv, xfer_eop;
  logic                       s1_vld, s1_sop, s1_eop;
  logic                       unused_lsb;
  logic signed [SAMPLE_W-1:0] mem [FFT_POINTS];

  assign s          = sample_in[31 -: SAMPLE_W];
  assign unused_lsb = ^sample_in;
  assign sum        = acc + ACW'(s);
  assign wdata      = SAMPLE_W'(sum >>> LD);
  assign fill_go    = (state == FILL) && sample_valid;
  assign we         = fill_go && (dcnt == DLAST);
  // Two-stage read pipe (RAM register, output register) stalls as a whole
  // whenever the output holds an untaken sample.
  assign adv        = !sink.sink_valid || sink.sink_ready;
  assign rd_en      = (state == STREAM) && !rd_done && adv;
  assign xfer_eop   = sink.sink_valid && sink.sink_ready && sink.sink_eop;

  assign busy            = (state == STREAM);
  assign fftpts_in       = (AW+1)'(FFT_POINTS);
  assign sink.sink_imag  = '0;
  assign sink.sink_error = '0;

  always_ff @(posedge CLOCK_50) begin
    if (we)    mem[wr_addr] <= wdata;
    if (rd_en) rd_data      <= mem[rd_addr];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state           <= FILL;
      wr_addr         <= '0;
      rd_addr         <= '0;
      rd_done         <= 1'b0;
      dcnt            <= '0;
      acc             <= '0;
      s1_vld          <= 1'b0;
      s1_sop          <= 1'b0;
      s1_eop          <= 1'b0;
      sink.sink_valid <= 1'b0;
      sink.sink_sop   <= 1'b0;
      sink.sink_eop   <= 1'b0;
      sink.sink_real  <= '0;
      dropped         <= 1'b0;
    end else begin
      dropped <= sample_valid && (state == STREAM);
      if (fill_go) begin
        if (we) begin
          acc     <= '0;
          dcnt    <= '0;
          wr_addr <= wr_addr + 1'b1;
          if (wr_addr == LAST_ADDR) state <= STREAM;
        end else begin
          acc  <= sum;
          dcnt <= dcnt + 1'b1;
        end
      end
      if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
        rd_done <= (rd_addr == LAST_ADDR);
      end
      if (adv) begin
        s1_vld          <= rd_en;
        s1_sop          <= (rd_addr == '0);
        s1_eop          <= (rd_addr == LAST_ADDR);
        sink.sink_valid <= s1_vld;
        if (s1_vld) begin
          sink.sink_real <= rd_data;
          sink.sink_sop  <= s1_sop;
          sink.sink_eop  <= s1_eop;
        end
      end
      // Frame done: back to filling, no partial decimation group survives.
      if (xfer_eop) begin
        state   <= FILL;
        rd_addr <= '0;
        rd_done <= 1'b0;
        acc     <= '0;
        dcnt    <= '0;
      end
    end
  end
endmodule
